// File: rtl/wb_host_master.sv
// Wishbone classic single-transfer master: turns a valid/ready command stream into
// one bus cycle per command and returns read data or a timeout error.
module wb_host_master #(
  parameter int DW      = 32,
  parameter int AW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_ni,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic            cmd_we,
  input  logic [AW-1:0]   cmd_adr,
  input  logic [DW-1:0]   cmd_dat,
  input  logic [DW/8-1:0] cmd_sel,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [DW-1:0]   rsp_dat,
  output logic            rsp_err,
  output logic            wbm_cyc_o,
  output logic            wbm_stb_o,
  output logic            wbm_we_o,
  output logic [DW/8-1:0] wbm_sel_o,
  output logic [AW-1:0]   wbm_adr_o,
  output logic [DW-1:0]   wbm_dat_o,
  input  logic            wbm_ack_i,
  input  logic [DW-1:0]   wbm_dat_i
);

  localparam int SW        = DW / 8;
  localparam int CW        = ($clog2(TIMEOUT + 1) < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam int TO_LAST_I = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
  localparam logic [CW-1:0] TO_LAST = CW'(TO_LAST_I);
  localparam logic TO_EN = (TIMEOUT != 0);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUS  = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]    state_q, state_d;
  logic          cyc_q, cyc_d;
  logic          we_q, we_d;
  logic [SW-1:0] sel_q, sel_d;
  logic [AW-1:0] adr_q, adr_d;
  logic [DW-1:0] dat_q, dat_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic          rsp_err_q, rsp_err_d;
  logic [DW-1:0] rsp_dat_q, rsp_dat_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d     = state_q;
    cyc_d       = cyc_q;
    we_d        = we_q;
    sel_d       = sel_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    rsp_dat_d   = rsp_dat_q;
    cnt_d       = cnt_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          we_d    = cmd_we;
          sel_d   = cmd_sel;
          adr_d   = cmd_adr;
          dat_d   = cmd_dat;
          cyc_d   = 1'b1;
          cnt_d   = '0;
          state_d = BUS;
        end
      end
      BUS: begin
        // Ack takes priority over a timeout expiring in the same cycle.
        if (wbm_ack_i) begin
          cyc_d       = 1'b0;
          rsp_dat_d   = we_q ? '0 : wbm_dat_i;
          rsp_err_d   = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else if (TO_EN && (cnt_q == TO_LAST)) begin
          cyc_d       = 1'b0;
          rsp_dat_d   = '0;
          rsp_err_d   = 1'b1;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else if (TO_EN) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      state_q     <= IDLE;
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      sel_q       <= '0;
      adr_q       <= '0;
      dat_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_dat_q   <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      we_q        <= we_d;
      sel_q       <= sel_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_dat_q   <= rsp_dat_d;
      cnt_q       <= cnt_d;
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_dat   = rsp_dat_q;
  assign rsp_err   = rsp_err_q;
  assign wbm_cyc_o = cyc_q;
  assign wbm_stb_o = cyc_q;
  assign wbm_we_o  = we_q;
  assign wbm_sel_o = sel_q;
  assign wbm_adr_o = adr_q;
  assign wbm_dat_o = dat_q;

endmodule

// File: tb/tb_wb_host_master.sv
// Directed bench for wb_host_master: a small Wishbone slave model plus a response scoreboard.
module tb_wb_host_master;

  localparam logic [31:0] RD_KEY = 32'h5A5A_A5A5;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [31:0] cmd_adr, cmd_dat;
  logic [3:0]  cmd_sel;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_dat;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_ack_i;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;

  int          passed = 0;
  int          total  = 0;
  int          cycles = 0;
  int          bus_cnt = 0;
  int          slave_wait = 0;
  logic        slave_never = 1'b0;
  logic        spur = 1'b0;
  logic        fn_mode = 1'b0;
  logic [31:0] slave_rdata = '0;
  logic [32:0] sb[$];

  always #5 clk = ~clk;

  wb_host_master #(.DW(32), .AW(32), .TIMEOUT(8)) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_adr(cmd_adr), .cmd_dat(cmd_dat), .cmd_sel(cmd_sel),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat), .rsp_err(rsp_err),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
    .wbm_sel_o(wbm_sel_o), .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
    .wbm_ack_i(wbm_ack_i), .wbm_dat_i(wbm_dat_i)
  );

  // Slave model: acks after slave_wait wait states, or never.
  always @(posedge clk) begin
    cycles <= cycles + 1;
    if (!wbm_cyc_o) bus_cnt <= 0;
    else            bus_cnt <= bus_cnt + 1;
  end

  assign wbm_ack_i = spur | (wbm_cyc_o & wbm_stb_o & ~slave_never & (bus_cnt == slave_wait));
  assign wbm_dat_i = fn_mode ? (wbm_adr_o ^ RD_KEY) : slave_rdata;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200us");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic run_cmd(input string tag, input logic we, input logic [31:0] adr,
                         input logic [31:0] dat, input logic [3:0] sel, input int exp_cyc,
                         input logic [31:0] exp_dat, input logic exp_err, input int bp);
    logic [32:0] e;
    int n;
    chk({tag, "_rdy0"}, 64'(cmd_ready), 64'd1);
    cmd_valid = 1'b1; cmd_we = we; cmd_adr = adr; cmd_dat = dat; cmd_sel = sel;
    rsp_ready = (bp == 0);
    sb.push_back({exp_err, exp_dat});
    step();
    cmd_valid = 1'b0; cmd_we = ~we; cmd_adr = ~adr; cmd_dat = ~dat; cmd_sel = ~sel;
    n = 0;
    while (wbm_cyc_o && n < 100) begin
      chk({tag, "_bus_ad"}, {wbm_adr_o, wbm_dat_o}, {adr, dat});
      chk({tag, "_bus_ctl"}, {wbm_stb_o, wbm_we_o, wbm_sel_o, cmd_ready},
          {1'b1, we, sel, 1'b0});
      n++;
      step();
    end
    chk({tag, "_cyc_len"}, 64'(n), 64'(exp_cyc));
    chk({tag, "_rsp_vld"}, 64'(rsp_valid), 64'd1);
    e = sb.pop_front();
    chk({tag, "_rsp"}, {rsp_err, rsp_dat}, e);
    for (int i = 0; i < bp; i++) begin
      cmd_valid = 1'b1;
      chk({tag, "_bp_rsp"}, {rsp_valid, rsp_err, rsp_dat}, {1'b1, e});
      chk({tag, "_bp_ctl"}, {cmd_ready, wbm_cyc_o}, 2'b00);
      step();
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    step();
    chk({tag, "_done"}, {rsp_valid, cmd_ready, wbm_cyc_o}, 3'b010);
  endtask

  initial begin
    logic [31:0] ra, rd;
    logic        rw;
    int          c0;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_dat = '0;
    cmd_sel = '0; rsp_ready = 1'b1;
    step(); step();
    chk("rst_bus", {wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o}, '0);
    chk("rst_ad", {wbm_adr_o, wbm_dat_o}, '0);
    chk("rst_rsp", {rsp_valid, rsp_err, rsp_dat}, '0);
    rst_n = 1'b1;
    chk("rst_rdy", 64'(cmd_ready), 64'd1);

    slave_wait = 0;
    run_cmd("wr0", 1'b1, 32'h3000_0004, 32'hDEAD_BEEF, 4'hF, 1, 32'h0, 1'b0, 0);

    slave_wait = 3; slave_rdata = 32'h1234_5678;
    run_cmd("rd3w", 1'b0, 32'h3000_0010, 32'h0, 4'hF, 4, 32'h1234_5678, 1'b0, 0);

    slave_never = 1'b1;
    run_cmd("tmo", 1'b1, 32'h3000_0020, 32'h0BAD_F00D, 4'h3, 8, 32'h0, 1'b1, 0);
    slave_never = 1'b0; slave_wait = 7; slave_rdata = 32'hA1B2_C3D4;
    run_cmd("ack8", 1'b0, 32'h3000_0024, 32'h0, 4'hF, 8, 32'hA1B2_C3D4, 1'b0, 0);

    slave_wait = 0; slave_rdata = 32'h5566_7788;
    run_cmd("bp", 1'b0, 32'h3000_0030, 32'h0, 4'hF, 1, 32'h5566_7788, 1'b0, 5);

    // Reset while the slave stalls in the second BUS cycle.
    slave_never = 1'b1;
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 32'h3000_0040; cmd_sel = 4'hF;
    step();
    cmd_valid = 1'b0;
    step();
    chk("mid_cyc", 64'(wbm_cyc_o), 64'd1);
    rst_n = 1'b0;
    step();
    chk("mid_rst", {wbm_cyc_o, wbm_stb_o, rsp_valid}, 3'b000);
    rst_n = 1'b1;
    chk("mid_rdy", 64'(cmd_ready), 64'd1);
    slave_never = 1'b0; slave_wait = 0; slave_rdata = 32'hCAFE_F00D;
    run_cmd("post", 1'b0, 32'h3000_0044, 32'h0, 4'hF, 1, 32'hCAFE_F00D, 1'b0, 0);

    spur = 1'b1;
    step();
    spur = 1'b0;
    chk("spur", {cmd_ready, wbm_cyc_o, rsp_valid, rsp_err}, 4'b1000);

    // Ten back-to-back commands with cmd_valid held high.
    fn_mode = 1'b1; rsp_ready = 1'b1;
    c0 = cycles;
    for (int i = 0; i < 10; i++) begin
      rw = 1'($urandom_range(0, 1));
      ra = $urandom; rd = $urandom;
      cmd_valid = 1'b1; cmd_we = rw; cmd_adr = ra; cmd_dat = rd; cmd_sel = 4'hF;
      sb.push_back({1'b0, rw ? 32'h0 : (ra ^ RD_KEY)});
      step();
      chk("b2b_bus", {wbm_cyc_o, wbm_we_o, wbm_adr_o}, {1'b1, rw, ra});
      step();
      chk("b2b_vld", {rsp_valid, wbm_cyc_o}, 2'b10);
      chk("b2b_rsp", {rsp_err, rsp_dat}, sb.pop_front());
      if (i == 9) cmd_valid = 1'b0;
      step();
    end
    chk("b2b_cycles", 64'(cycles - c0), 64'd30);
    chk("b2b_idle", {cmd_ready, rsp_valid, wbm_cyc_o}, 3'b100);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
